cipher_stream_ctrl: RTL and testbench

CIPHER_STREAM_CTRL -- requirements
Module: cipher_stream_ctrl

---
 rtl/cipher_stream_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cipher_stream_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_stream_ctrl.sv
// Vigenere-style byte stream cipher: a key table of SEC_LEN ASCII letters
// shifts letter bytes of a message forward (encrypt) or back (decrypt).
// One input byte per cycle, one registered output stage, valid/ready on both
// sides, and a done pulse after the last output byte leaves.

// Per-byte transform: key byte -> shift, then rotate a letter within its case.
module cipher_byte_xform (
  input  logic [7:0] c,
  input  logic [7:0] k,
  input  logic       dec,
  output logic [7:0] y,
  output logic       is_alpha
);
  logic       c_up, c_lo, k_up, k_lo;
  logic [4:0] s, off;
  logic [5:0] sum;
  logic [7:0] base;

  assign c_up     = (c >= 8'h41) && (c <= 8'h5a);
  assign c_lo     = (c >= 8'h61) && (c <= 8'h7a);
  assign k_up     = (k >= 8'h41) && (k <= 8'h5a);
  assign k_lo     = (k >= 8'h61) && (k <= 8'h7a);
  assign is_alpha = c_up || c_lo;

  // Shift amount, rotation within 0..25, and the re-based result byte.
  always_comb begin
    s    = 5'd0;
    base = 8'h61;
    off  = 5'd0;
    sum  = 6'd0;
    y    = c;
    if (k_up)      s = 5'(k - 8'h41);
    else if (k_lo) s = 5'(k - 8'h61);
    if (c_up) base = 8'h41;
    off = 5'(c - base);
    // operands stay below 52, so a single conditional subtract wraps them
    if (dec) sum = {1'b0, off} + 6'd26 - {1'b0, s};
    else     sum = {1'b0, off} + {1'b0, s};
    if (sum >= 6'd26) sum = sum - 6'd26;
    if (is_alpha) y = base + {3'b000, sum[4:0]};
  end
endmodule

module cipher_stream_ctrl #(
  parameter  int SEC_LEN = 3,
  parameter  int LEN_W   = 8,
  localparam int AW      = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             key_we,
  input  logic [AW-1:0]    key_addr,
  input  logic [7:0]       key_data,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic                        mode_q;
  logic [LEN_W-1:0]            len_q, cnt_q;
  logic [AW-1:0]               key_idx_q;
  logic [SEC_LEN-1:0][7:0]     key_mem;
  logic [7:0]                  cur_key, xf_byte;
  logic                        xf_alpha;
  logic                        in_xfer, out_xfer, last_in, accept;

  assign in_ready = (state_q == S_RUN) && (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign last_in  = (cnt_q == len_q - LEN_W'(1));
  assign accept   = (state_q == S_IDLE) && start;

  // Select the key byte in use; a mux loop keeps SEC_LEN=1 index-width clean.
  always_comb begin
    cur_key = 8'h41;
    for (int i = 0; i < SEC_LEN; i++)
      if (key_idx_q == AW'(i)) cur_key = key_mem[i];
  end

  cipher_byte_xform u_xf (
    .c        (in_data),
    .k        (cur_key),
    .dec      (mode_q),
    .y        (xf_byte),
    .is_alpha (xf_alpha)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (msg_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (in_xfer && last_in) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (out_xfer) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Message context: mode/length latch, byte count, key index.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      key_idx_q <= '0;
    end else if (accept && (msg_len != '0)) begin
      mode_q    <= mode;
      len_q     <= msg_len;
      cnt_q     <= '0;
      key_idx_q <= '0;
    end else if (in_xfer) begin
      cnt_q <= cnt_q + LEN_W'(1);
      // only letters consume a key byte
      if (xf_alpha)
        key_idx_q <= (key_idx_q == AW'(SEC_LEN - 1)) ? '0 : key_idx_q + AW'(1);
    end
  end

  // Key table: written only while idle; out-of-range addresses match nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEC_LEN; i++) key_mem[i] <= 8'h41;
    end else if ((state_q == S_IDLE) && key_we) begin
      for (int i = 0; i < SEC_LEN; i++)
        if (key_addr == AW'(i)) key_mem[i] <= key_data;
    end
  end

  // Output register: loads on input transfer, empties on output transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= xf_byte;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Bench for cipher_stream_ctrl: a cycle-level behavioural model checked on
// every falling edge, directed messages with literal expected strings, and a
// second SEC_LEN=1 instance for key/alphabet wrap.
module tb_cipher_stream_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0 (SEC_LEN=3) ----------------
  logic       rst = 1'b1, mode = 1'b0, start = 1'b0, key_we = 1'b0;
  logic [7:0] msg_len = '0, key_data = '0, in_data = '0;
  logic [1:0] key_addr = '0;
  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic       in_ready, out_valid, busy, done;
  logic [7:0] out_data;

  cipher_stream_ctrl #(.SEC_LEN(3), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .msg_len(msg_len),
    .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done));

  // ---------------- DUT 1 (SEC_LEN=1) ----------------
  logic       rst1 = 1'b1, mode1 = 1'b0, start1 = 1'b0, key_we1 = 1'b0;
  logic [7:0] msg_len1 = '0, key_data1 = '0, in_data1 = '0;
  logic [0:0] key_addr1 = '0;
  logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic       in_ready1, out_valid1, busy1, done1;
  logic [7:0] out_data1;

  cipher_stream_ctrl #(.SEC_LEN(1), .LEN_W(8)) dut1 (
    .clk(clk), .rst(rst1), .mode(mode1), .start(start1), .msg_len(msg_len1),
    .key_we(key_we1), .key_addr(key_addr1), .key_data(key_data1),
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
    .busy(busy1), .done(done1));

  int n_vec = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_letter(input int c);
    return (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
  endfunction

  function automatic int model_x(input int c, input int k, input bit dec);
    int s, base;
    s = (k >= 65 && k <= 90) ? k - 65 : (k >= 97 && k <= 122) ? k - 97 : 0;
    if (!is_letter(c)) return c;
    base = (c <= 90) ? 65 : 97;
    return base + ((c - base + (dec ? 26 - s : s)) % 26);
  endfunction

  bit  m_busy = 0, m_done = 0, m_ov = 0, m_mode = 0;
  int  m_od = 0, m_in_left = 0, m_kidx = 0;
  int  m_keys[3] = '{65, 65, 65};
  byte got[$];
  int  done_cnt = 0;

  // Compare DUT against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    bit idle, in_x, out_x, n_done;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("in_ready", in_ready, m_busy && m_in_left != 0 && (!m_ov || out_ready));
    if (out_valid && out_ready) got.push_back(out_data);
    if (done) done_cnt++;

    idle  = !m_busy && !m_done;
    in_x  = m_busy && m_in_left > 0 && in_valid && (!m_ov || out_ready);
    out_x = m_ov && out_ready;
    if (rst) begin
      m_busy = 0; m_done = 0; m_ov = 0; m_od = 0; m_in_left = 0; m_kidx = 0;
      m_mode = 0; m_keys = '{65, 65, 65};
    end else begin
      n_done = 0;
      if (idle) begin
        if (key_we && key_addr < 3) m_keys[key_addr] = key_data;
        if (start) begin
          if (msg_len == 0) n_done = 1;
          else begin
            m_busy = 1; m_in_left = msg_len; m_kidx = 0; m_mode = mode;
          end
        end
      end else if (m_busy) begin
        if (m_in_left == 0 && out_x) begin m_busy = 0; n_done = 1; end
        if (out_x) m_ov = 0;
        if (in_x) begin
          m_ov = 1;
          m_od = model_x(in_data, m_keys[m_kidx], m_mode);
          if (is_letter(in_data)) m_kidx = (m_kidx + 1) % 3;
          m_in_left--;
        end
      end
      m_done = n_done;
    end
  end

  byte got1[$];
  int  done1_cnt = 0;
  // Capture for the SEC_LEN=1 instance.
  always @(negedge clk) begin
    if (out_valid1 && out_ready1) got1.push_back(out_data1);
    if (done1) done1_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic string q2s(input byte q[$]);
    string s = "";
    foreach (q[i]) s = {s, string'(q[i])};
    return s;
  endfunction

  task automatic write_key(input string k);
    for (int i = 0; i < k.len(); i++) begin
      key_we = 1; key_addr = 2'(i); key_data = k[i]; tick();
    end
    key_we = 0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({name, "_done_seen"}, seen, 1);
    tick();
  endtask

  // Send one message; optional stall window, mid-run start/key write,
  // and a key write issued together with start.
  task automatic send_msg(input string name, input bit md, input string s,
                          input int stall_at, input int stall_len,
                          input int mid_at, input int start_key);
    int idx = 0, cyc = 0, d0;
    bit xfer;
    got.delete();
    d0 = done_cnt;
    start = 1; mode = md; msg_len = 8'(s.len());
    if (start_key >= 0) begin key_we = 1; key_addr = 0; key_data = 8'(start_key); end
    tick();
    start = 0; key_we = 0;
    while (idx < s.len() && cyc < 200) begin
      in_valid  = 1; in_data = s[idx];
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      start = (cyc == mid_at); msg_len = (cyc == mid_at) ? 8'd9 : msg_len;
      key_we = (cyc == mid_at); key_addr = 0; key_data = 8'h41;
      @(negedge clk);
      xfer = in_ready;
      tick();
      if (xfer) idx++;
      cyc++;
    end
    in_valid = 0; start = 0; key_we = 0; out_ready = 1;
    chk({name, "_all_sent"}, idx, s.len());
    wait_done(name);
    tick(); tick();
    chk({name, "_done_once"}, done_cnt - d0, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0, oc;
    string r;
    tick(); tick();
    rst = 0; rst1 = 0;
    @(negedge clk);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    tick();

    write_key("KEY");
    send_msg("enc", 0, "HeLlO", 99, 0, -1, -1);
    chk_str("enc_out", q2s(got), "RiJvS");
    send_msg("dec", 1, "RiJvS", 99, 0, -1, -1);
    chk_str("dec_out", q2s(got), "HeLlO");
    send_msg("space", 0, "a b", 99, 0, -1, -1);
    chk_str("space_out", q2s(got), "k f");
    send_msg("stall", 0, "HeLlO", 2, 3, 1, -1);
    chk_str("stall_out", q2s(got), "RiJvS");

    // zero-length message: done on the next cycle, nothing on the output
    d0 = done_cnt; oc = got.size();
    start = 1; msg_len = 0; tick(); start = 0;
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_out_valid", out_valid, 0);
    tick(); tick();
    chk("len0_done_once", done_cnt - d0, 1);
    chk("len0_no_out", got.size(), oc);

    // key byte 0 rewritten in the same cycle as start: "a" + 'B' -> "b"
    send_msg("kw_start", 0, "a", 99, 0, -1, 66);
    chk_str("kw_start_out", q2s(got), "b");

    // reset after 2 of 5 bytes
    d0 = done_cnt;
    start = 1; mode = 0; msg_len = 5; tick(); start = 0;
    in_valid = 1; in_data = "H"; tick();
    in_data = "e"; tick();
    in_valid = 0; rst = 1; tick(); rst = 0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_data", out_data, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    tick(); tick(); tick();
    chk("rst_mid_no_done", done_cnt - d0, 0);

    // SEC_LEN=1 instance: key "B", "zz" -> "aa"
    key_we1 = 1; key_addr1 = 0; key_data1 = "B"; tick(); key_we1 = 0;
    start1 = 1; msg_len1 = 2; mode1 = 0; tick(); start1 = 0;
    begin
      int idx = 0;
      bit xf;
      for (int c = 0; c < 20 && idx < 2; c++) begin
        in_valid1 = 1; in_data1 = "z";
        @(negedge clk); xf = in_ready1; tick();
        if (xf) idx++;
      end
      in_valid1 = 0;
    end
    for (int i = 0; i < 40 && done1_cnt == 0; i++) tick();
    chk_str("sec1_out", q2s(got1), "aa");
    chk("sec1_done", done1_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
